custom_instr_rand_mc: RTL and testbench

- Parametrised multicycle NiosII custom instruction providing CHANNELS independent Xorshift128 generators.
- Supports seed write, peek, advance and reset-to-default per channel.
- Adds a scaled-range operation, floor(w*dataa/2^32), built on a 32-step iterative shift-add multiplier.
- Sits on the NiosII custom-instruction port as a multicycle (start/done) slave.

---
 rtl/custom_instr_rand_mc_pkg.sv | 32 +++
 rtl/custom_instr_rand_mc_if.sv | 13 +
 rtl/custom_instr_rand_mc_channel.sv | 84 ++++++++
 rtl/custom_instr_rand_mc.sv | 139 +++++++++++++
 tb/tb_custom_instr_rand_mc.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/custom_instr_rand_mc_pkg.sv
// Shared constants, FSM encoding and seed helper for the multicycle
// Xorshift128 custom instruction.
package custom_instr_rand_pkg;

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_PEEK     = 3'd1;
  localparam logic [2:0] OP_SEED     = 3'd2;
  localparam logic [2:0] OP_RANGE    = 3'd3;
  localparam logic [2:0] OP_RESET_CH = 3'd4;

  localparam int unsigned MUL_STEPS = 32;

  localparam logic [31:0] DEF_SEED_X      = 32'd123456789;
  localparam logic [31:0] DEF_SEED_Y      = 32'd362436069;
  localparam logic [31:0] DEF_SEED_Z      = 32'd521288629;
  localparam logic [31:0] DEF_SEED_W      = 32'd88675123;
  localparam logic [31:0] DEF_SEED_STRIDE = 32'h9E3779B9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_RESP
  } state_e;

  // Default word for channel ch: base + ch*stride (mod 2^32)
  function automatic logic [31:0] chan_seed(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input int unsigned ch);
    return base + (32'(ch) * stride);
  endfunction

endpackage

// File: rtl/custom_instr_rand_mc_if.sv
// NiosII custom-instruction port bundle (clk/reset_n stay plain ports).
interface custom_instr_rand_mc_if;
  logic        clk_en;
  logic        start;
  logic [7:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (output clk_en, start, n, dataa, datab, input result, done);
  modport slave  (input clk_en, start, n, dataa, datab, output result, done);
endinterface

// File: rtl/custom_instr_rand_mc_channel.sv
// One Xorshift128 generator: step logic, guarded seed-word write,
// restore-to-default, and held w / selected-word read outputs.
module rand_channel
  import custom_instr_rand_pkg::*;
#(
  parameter logic [31:0] P_X = DEF_SEED_X,
  parameter logic [31:0] P_Y = DEF_SEED_Y,
  parameter logic [31:0] P_Z = DEF_SEED_Z,
  parameter logic [31:0] P_W = DEF_SEED_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_adv,
  input  logic        i_wr,
  input  logic        i_restore,
  input  logic [1:0]  i_wsel,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_w,
  output logic [31:0] o_rd
);

  logic [31:0] r_x, r_y, r_z, r_w;
  logic [31:0] w_t, w_step_w;
  logic [31:0] w_nx, w_ny, w_nz, w_nw;

  // Xorshift128 next-w term
  always_comb begin
    w_t      = r_x ^ (r_x << 11);
    w_step_w = r_w ^ (r_w >> 19) ^ w_t ^ (w_t >> 8);
  end

  // Seed-word write with all-zero lock-up guard on w
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    w_nz = r_z;
    w_nw = r_w;
    case (i_wsel)
      2'd0:    w_nx = i_wdata;
      2'd1:    w_ny = i_wdata;
      2'd2:    w_nz = i_wdata;
      default: w_nw = i_wdata;
    endcase
    if ({w_nx, w_ny, w_nz, w_nw} == '0) w_nw = 32'h0000_0001;
  end

  // Old value of the selected word, returned by SEED
  always_comb begin
    case (i_wsel)
      2'd0:    o_rd = r_x;
      2'd1:    o_rd = r_y;
      2'd2:    o_rd = r_z;
      default: o_rd = r_w;
    endcase
  end

  assign o_w = r_w;

  // Generator state: restore has priority over write, write over advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= P_X;
      r_y <= P_Y;
      r_z <= P_Z;
      r_w <= P_W;
    end else if (i_restore) begin
      r_x <= P_X;
      r_y <= P_Y;
      r_z <= P_Z;
      r_w <= P_W;
    end else if (i_wr) begin
      r_x <= w_nx;
      r_y <= w_ny;
      r_z <= w_nz;
      r_w <= w_nw;
    end else if (i_adv) begin
      r_x <= r_y;
      r_y <= r_z;
      r_z <= r_w;
      r_w <= w_step_w;
    end
  end

endmodule

// File: rtl/custom_instr_rand_mc.sv
// Multicycle NiosII custom instruction: CHANNELS Xorshift128 generators
// plus floor(w*dataa/2^32) via a 32-step shift-add multiplier.
module custom_instr_rand_mc
  import custom_instr_rand_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter logic [31:0] SEED_X      = DEF_SEED_X,
  parameter logic [31:0] SEED_Y      = DEF_SEED_Y,
  parameter logic [31:0] SEED_Z      = DEF_SEED_Z,
  parameter logic [31:0] SEED_W      = DEF_SEED_W,
  parameter logic [31:0] SEED_STRIDE = DEF_SEED_STRIDE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  custom_instr_rand_mc_if.slave bus
);

  logic [2:0]          w_op;
  logic [1:0]          w_ch;
  logic                w_accept;
  logic [CHANNELS-1:0] w_adv, w_wr, w_rst;
  logic [31:0]         w_ch_w  [CHANNELS];
  logic [31:0]         w_ch_rd [CHANNELS];
  logic [31:0]         w_sel_w, w_sel_rd, w_imm;
  logic [63:0]         w_acc_next;
  logic                w_unused;

  state_e      r_state;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_done;

  assign w_op     = bus.n[2:0];
  assign w_ch     = bus.n[4:3];
  assign w_accept = bus.clk_en && bus.start && (r_state == ST_IDLE);
  assign w_unused = ^{bus.n[7:5], bus.datab[31:2]};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    rand_channel #(
      .P_X(chan_seed(SEED_X, SEED_STRIDE, g)),
      .P_Y(chan_seed(SEED_Y, SEED_STRIDE, g)),
      .P_Z(chan_seed(SEED_Z, SEED_STRIDE, g)),
      .P_W(chan_seed(SEED_W, SEED_STRIDE, g))
    ) u_ch (
      .i_clk    (clk),
      .i_rst_n  (reset_n),
      .i_adv    (w_adv[g]),
      .i_wr     (w_wr[g]),
      .i_restore(w_rst[g]),
      .i_wsel   (bus.datab[1:0]),
      .i_wdata  (bus.dataa),
      .o_w      (w_ch_w[g]),
      .o_rd     (w_ch_rd[g])
    );
  end

  // Channel select and per-channel strobes; an absent channel reads as 0 and gets no strobe
  always_comb begin
    w_sel_w  = '0;
    w_sel_rd = '0;
    w_adv    = '0;
    w_wr     = '0;
    w_rst    = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_ch == 2'(c)) begin
        w_sel_w  = w_ch_w[c];
        w_sel_rd = w_ch_rd[c];
        if (w_accept) begin
          w_adv[c] = (w_op == OP_NEXT) || (w_op == OP_RANGE);
          w_wr[c]  = (w_op == OP_SEED);
          w_rst[c] = (w_op == OP_RESET_CH);
        end
      end
    end
  end

  // Immediate result for single-cycle opcodes
  always_comb begin
    case (w_op)
      OP_NEXT, OP_PEEK: w_imm = w_sel_w;
      OP_SEED:          w_imm = w_sel_rd;
      default:          w_imm = '0;
    endcase
  end

  // One shift-add step
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Control FSM; non-RANGE results are staged in r_acc[63:32] so RESP has one load path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (bus.clk_en) begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            if (w_op == OP_RANGE) begin
              r_mcand  <= {32'b0, w_sel_w};
              r_mplier <= bus.dataa;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= ST_MUL;
            end else begin
              r_acc   <= {w_imm, 32'b0};
              r_state <= ST_RESP;
            end
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'(MUL_STEPS - 1)) r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_result <= r_acc[63:32];
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_custom_instr_rand_mc.sv
// Scoreboard bench for custom_instr_rand_mc (CHANNELS=2).
module tb_custom_instr_rand_mc;

  localparam logic [2:0] K_NEXT = 3'd0, K_PEEK = 3'd1, K_SEED = 3'd2,
                         K_RANGE = 3'd3, K_RST = 3'd4;

  typedef struct {
    logic [31:0] exp;
    int          cyc;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  exp_t q[$];
  logic [31:0] ms [2][4];

  custom_instr_rand_mc_if bus();

  custom_instr_rand_mc #(.CHANNELS(2)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", nm, act, act, exp, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_done: got done=1 at cycle %0d, expected no done", cyc);
        end else begin
          e = q.pop_front();
          chk({e.nm, "_result"}, bus.result, e.exp);
          chk({e.nm, "_latency"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  function automatic void m_reset_ch(input int c);
    ms[c][0] = 32'd123456789 + 32'(c) * 32'h9E3779B9;
    ms[c][1] = 32'd362436069 + 32'(c) * 32'h9E3779B9;
    ms[c][2] = 32'd521288629 + 32'(c) * 32'h9E3779B9;
    ms[c][3] = 32'd88675123  + 32'(c) * 32'h9E3779B9;
  endfunction

  function automatic void m_step(input int c);
    logic [31:0] t;
    t = ms[c][0] ^ (ms[c][0] << 11);
    ms[c][0] = ms[c][1];
    ms[c][1] = ms[c][2];
    ms[c][2] = ms[c][3];
    ms[c][3] = ms[c][3] ^ (ms[c][3] >> 19) ^ t ^ (t >> 8);
  endfunction

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within 100 cycles, expected done", nm);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] ch, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input string nm);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = {3'b000, ch, op};
    bus.dataa = a;
    bus.datab = b;
    q.push_back('{exp, cyc + 1 + lat, nm});
    @(negedge clk);
    bus.start = 1'b0;
    wait_empty(nm);
  endtask

  task automatic do_next(input int c, input string nm);
    if (c < 2) begin
      issue(K_NEXT, 2'(c), 32'd0, 32'd0, ms[c][3], 1, nm);
      m_step(c);
    end else begin
      issue(K_NEXT, 2'(c), 32'd0, 32'd0, 32'd0, 1, nm);
    end
  endtask

  task automatic do_peek(input int c, input string nm);
    issue(K_PEEK, 2'(c), 32'd0, 32'd0, (c < 2) ? ms[c][3] : 32'd0, 1, nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_reset_ch(0);
    m_reset_ch(1);
    @(negedge clk);
  endtask

  initial begin
    int t0;
    int d0;
    bus.clk_en = 1'b1;
    bus.start  = 1'b0;
    bus.n      = '0;
    bus.dataa  = '0;
    bus.datab  = '0;
    m_reset_ch(0);
    m_reset_ch(1);
    repeat (3) @(negedge clk);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Known sequence and PEEK stability
    issue(K_NEXT, 2'd0, 32'd0, 32'd0, 32'd88675123, 1, "next0_a");
    m_step(0);
    issue(K_NEXT, 2'd0, 32'd0, 32'd0, 32'd3701687786, 1, "next0_b");
    m_step(0);
    do_peek(0, "peek0_a");
    do_peek(0, "peek0_b");

    // RANGE with dataa=all-ones gives w-1; channel advanced once
    do_reset();
    issue(K_RANGE, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'd88675122, 33, "range_max");
    m_step(0);
    issue(K_PEEK, 2'd0, 32'd0, 32'd0, 32'd3701687786, 1, "peek_after_range");
    issue(K_RANGE, 2'd0, 32'd0, 32'd0, 32'd0, 33, "range_zero");
    m_step(0);
    issue(K_RANGE, 2'd0, 32'h8000_0000, 32'd0, ms[0][3] >> 1, 33, "range_half");
    m_step(0);

    // SEED ch1 all-zero: old defaults returned, lock-up guard forces w=1
    for (int w = 0; w < 4; w++) begin
      issue(K_SEED, 2'd1, 32'd0, 32'(w), ms[1][w], 1, "seed1");
      ms[1][w] = 32'd0;
    end
    ms[1][3] = 32'd1;
    issue(K_PEEK, 2'd1, 32'd0, 32'd0, 32'd1, 1, "peek1_guard");
    for (int i = 0; i < 3; i++) do_next(1, "next1");
    issue(K_SEED, 2'd1, 32'hDEAD_BEEF, 32'd2, ms[1][2], 1, "seed1_z");
    ms[1][2] = 32'hDEAD_BEEF;
    do_next(1, "next1_after_seed");

    // Isolation, absent channel, reserved opcode
    do_peek(0, "peek0_isol");
    do_next(3, "next_ch3");
    issue(K_SEED, 2'd3, 32'h1234_5678, 32'd3, 32'd0, 1, "seed_ch3");
    issue(3'd6, 2'd0, 32'd0, 32'd0, 32'd0, 1, "reserved6");
    do_peek(0, "peek0_after_ch3");
    do_peek(1, "peek1_after_ch3");

    // Stalled RANGE with ignored start pulse mid-multiply
    do_reset();
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = {3'b000, 2'd0, K_RANGE};
    bus.dataa = 32'hFFFF_FFFF;
    q.push_back('{32'd88675122, cyc + 1 + 38, "range_stall"});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.n     = {3'b000, 2'd0, K_NEXT};
    @(negedge clk);
    bus.start  = 1'b0;
    bus.clk_en = 1'b0;
    repeat (5) @(negedge clk);
    bus.clk_en = 1'b1;
    wait_empty("range_stall");
    m_step(0);
    issue(K_PEEK, 2'd0, 32'd0, 32'd0, 32'd3701687786, 1, "peek_after_stall");

    // Reset asserted 10 cycles into a RANGE: no done, defaults restored
    do_reset();
    do_next(0, "next_pre_abort");
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = {3'b000, 2'd0, K_RANGE};
    bus.dataa = 32'h0000_1234;
    t0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 50 && cyc < t0 + 10; i++) @(posedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset_ch(0);
    m_reset_ch(1);
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    issue(K_PEEK, 2'd0, 32'd0, 32'd0, 32'd88675123, 1, "peek_after_abort");

    // RESET_CH restores the default sequence of ch0 only
    for (int i = 0; i < 3; i++) do_next(0, "next0_pre_rst");
    do_next(1, "next1_pre_rst");
    issue(K_RST, 2'd0, 32'd0, 32'd0, 32'd0, 1, "reset_ch0");
    m_reset_ch(0);
    issue(K_NEXT, 2'd0, 32'd0, 32'd0, 32'd88675123, 1, "next0_rst_a");
    m_step(0);
    issue(K_NEXT, 2'd0, 32'd0, 32'd0, 32'd3701687786, 1, "next0_rst_b");
    m_step(0);
    do_peek(1, "peek1_after_rst0");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
